// File: rtl/pito_mvu_launcher.sv
// Per-hart MVU job launcher: CSR write -> mvu_start 2 cycles later, one job in flight per hart.
// Writes to a full queue are dropped and flagged; watchdog timeout only with PITO_MVU_TIMEOUT_EN.
module pito_mvu_launcher #(
   parameter int NUM_HARTS   = 8,
   parameter int CMD_DEPTH   = 2,
   parameter int MVU_TIMEOUT = 65535
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_HARTS-1:0]     csr_mvucommand_we,
   input  logic [32*NUM_HARTS-1:0]  csr_mvucommand,
   input  logic [NUM_HARTS-1:0]     mvu_irq_i,
   input  logic [NUM_HARTS-1:0]     irq_ack_i,
   output logic [NUM_HARTS-1:0]     mvu_start,
   output logic [32*NUM_HARTS-1:0]  mvu_command,
   output logic [NUM_HARTS-1:0]     hart_irq_o,
   output logic [32*NUM_HARTS-1:0]  csr_mvustatus,
   output logic [NUM_HARTS-1:0]     cmd_full_o
);
   typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_e;

   if (NUM_HARTS < 1 || NUM_HARTS > 16 || CMD_DEPTH < 1 || CMD_DEPTH > 8 ||
       (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || MVU_TIMEOUT < 1) begin : g_param_err
      $error("pito_mvu_launcher: parameter out of range");
   end

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      state_e      state_q, state_d;
      logic [3:0]  count, count_d;
      logic [31:0] head, cmd_q, cmd_d, status_q, status_d;
      logic        full, empty, push, pop, done, tmo_hit;
      logic        start_q, start_d, full_q, full_d;
      logic        pend_q, pend_d, ovf_q, ovf_d, tmo_q, tmo_d, spur_q, spur_d;

      pito_mvu_cmd_fifo #(
         .W     (32),
         .DEPTH (CMD_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push_i  (push),
         .pop_i   (pop),
         .dat_i   (csr_mvucommand[32*h +: 32]),
         .dat_o   (head),
         .count_o (count)
      );

      assign full  = (count == 4'(CMD_DEPTH));
      assign empty = (count == 4'd0);

`ifdef PITO_MVU_TIMEOUT_EN
      logic [31:0] wd_q;

      always_ff @(posedge clk) begin
         if (rst || state_q != BUSY) wd_q <= '0;
         else                        wd_q <= wd_q + 32'd1;
      end

      // Fires on the MVU_TIMEOUT-th consecutive BUSY cycle.
      assign tmo_hit = (state_q == BUSY) && (wd_q == 32'(MVU_TIMEOUT - 1));
`else
      assign tmo_hit = 1'b0;
`endif

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            start_q  <= 1'b0;
            full_q   <= 1'b0;
            pend_q   <= 1'b0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
            spur_q   <= 1'b0;
            status_q <= '0;
         end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            start_q  <= start_d;
            full_q   <= full_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
            spur_q   <= spur_d;
            status_q <= status_d;
         end
      end

      always_comb begin
         state_d = state_q;
         pop     = 1'b0;
         case (state_q)
            IDLE: begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = LAUNCH;
               end
            end
            LAUNCH: state_d = BUSY;
            BUSY: begin
               if (mvu_irq_i[h] || tmo_hit) begin
                  if (!empty) begin
                     pop     = 1'b1;
                     state_d = LAUNCH;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Outputs are registered from next-state values so they line up with state_q.
      always_comb begin
         done     = (state_q == BUSY) && mvu_irq_i[h];
         push     = csr_mvucommand_we[h] && (!full || pop);
         cmd_d    = pop ? head : cmd_q;
         start_d  = (state_d == LAUNCH);
         count_d  = count + 4'(push) - 4'(pop);
         full_d   = (count_d == 4'(CMD_DEPTH));
         pend_d   = done || tmo_hit || (pend_q && !irq_ack_i[h]);
         ovf_d    = (csr_mvucommand_we[h] && !push) || (ovf_q && !irq_ack_i[h]);
         tmo_d    = (tmo_hit && !mvu_irq_i[h]) || (tmo_q && !irq_ack_i[h]);
         spur_d   = (mvu_irq_i[h] && state_q != BUSY) || (spur_q && !irq_ack_i[h]);
         status_d = {20'd0, count_d, 3'd0, spur_d, tmo_d, ovf_d, pend_d, state_d != IDLE};
      end

      assign mvu_start[h]               = start_q;
      assign mvu_command[32*h +: 32]    = cmd_q;
      assign hart_irq_o[h]              = pend_q;
      assign csr_mvustatus[32*h +: 32]  = status_q;
      assign cmd_full_o[h]              = full_q;
   end
endmodule

// Generic synchronous FIFO, head visible combinationally; caller never pops empty or pushes full
// unless popping in the same cycle.
module pito_mvu_cmd_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] dat_i,
   output logic [W-1:0] dat_o,
   output logic [3:0]   count_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [3:0]    count_q;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push_i && !rst) mem_q[wr_ptr_q] <= dat_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + 4'(push_i) - 4'(pop_i);
      end
   end

   assign dat_o   = mem_q[rd_ptr_q];
   assign count_o = count_q;
endmodule

// File: tb/tb_pito_mvu_launcher.sv
// Directed bench for pito_mvu_launcher; launched commands are scoreboarded per hart.
module tb_pito_mvu_launcher;
   localparam int NH = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [NH-1:0]   we, irq, ack, start, hirq, full;
   logic [32*NH-1:0] cmd, mcmd, status;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q [NH][$];

   pito_mvu_launcher #(
      .NUM_HARTS   (NH),
      .CMD_DEPTH   (2),
      .MVU_TIMEOUT (100)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .csr_mvucommand_we (we),
      .csr_mvucommand    (cmd),
      .mvu_irq_i         (irq),
      .irq_ack_i         (ack),
      .mvu_start         (start),
      .mvu_command       (mcmd),
      .hart_irq_o        (hirq),
      .csr_mvustatus     (status),
      .cmd_full_o        (full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] st(input int h);
      return status[32*h +: 32];
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic write(input int h, input logic [31:0] c, input bit accepted);
      we[h] = 1'b1;
      cmd[32*h +: 32] = c;
      if (accepted) exp_q[h].push_back(c);
   endtask

   // Returns at the first BUSY cycle of the job.
   task automatic start_job(input int h, input logic [31:0] c);
      write(h, c, 1'b1);
      tick();
      we[h] = 1'b0;
      chk("lat_early", start[h], 1'b0);
      tick();
      chk("lat_start", start[h], 1'b1);
      tick();
      chk("lat_pulse", start[h], 1'b0);
   endtask

   task automatic finish_job(input int h);
      irq[h] = 1'b1;
      tick();
      irq[h] = 1'b0;
      chk("done_irq", hirq[h], 1'b1);
      chk("done_status", st(h), 32'h2);
      ack[h] = 1'b1;
      tick();
      ack[h] = 1'b0;
      chk("ack_irq", hirq[h], 1'b0);
      chk("ack_status", st(h), 32'h0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int h = 0; h < NH; h++) begin
            if (start[h]) begin
               checks++;
               assert (exp_q[h].size() != 0) else begin
                  failures++;
                  $error("FAIL sb_unexpected_start hart=%0d observed=start expected=none", h);
               end
               if (exp_q[h].size() != 0) chk("sb_cmd", mcmd[32*h +: 32], exp_q[h].pop_front());
            end
         end
      end
   end

   initial begin
      rst = 1'b1; we = '0; cmd = '0; irq = '0; ack = '0;
      tick(2);
      write(0, 32'h0000_DEAD, 1'b0);
      tick();
      chk("rst_start", start, '0);
      chk("rst_cmd", mcmd, '0);
      chk("rst_irq", hirq, '0);
      chk("rst_status", status, '0);
      chk("rst_full", full, '0);
      rst = 1'b0;
      we  = '0;
      tick(3);
      chk("rst_write_dropped", status, '0);

      // Basic launch latency and command hold.
      write(0, 32'h0000_00A5, 1'b1);
      tick();
      we[0] = 1'b0;
      chk("a5_early", start[0], 1'b0);
      tick();
      chk("a5_start", start[0], 1'b1);
      chk("a5_cmd", mcmd[31:0], 32'hA5);
      chk("a5_busy", st(0), 32'h1);
      tick();
      chk("a5_pulse", start[0], 1'b0);
      chk("a5_hold", mcmd[31:0], 32'hA5);
      chk("a5_busy2", st(0), 32'h1);
      finish_job(0);

      // Overflow on a full queue, then in-order drain.
      start_job(3, 32'h31);
      write(3, 32'h32, 1'b1);
      tick();
      write(3, 32'h33, 1'b1);
      tick();
      write(3, 32'h34, 1'b0);
      tick();
      we[3] = 1'b0;
      chk("ovf_full", full[3], 1'b1);
      chk("ovf_status", st(3), 32'h205);
      irq[3] = 1'b1;
      tick();
      irq[3] = 1'b0;
      chk("ovf_relaunch1", start[3], 1'b1);
      chk("ovf_notfull", full[3], 1'b0);
      chk("ovf_status1", st(3), 32'h107);
      tick();
      irq[3] = 1'b1;
      tick();
      irq[3] = 1'b0;
      chk("ovf_relaunch2", start[3], 1'b1);
      chk("ovf_status2", st(3), 32'h007);
      tick();
      irq[3] = 1'b1;
      tick();
      irq[3] = 1'b0;
      chk("ovf_irq", hirq[3], 1'b1);
      chk("ovf_status3", st(3), 32'h006);
      ack[3] = 1'b1;
      tick();
      ack[3] = 1'b0;
      chk("ovf_cleared", st(3), 32'h0);

      // Done and ack in the same cycle: set wins.
      start_job(1, 32'h11);
      irq[1] = 1'b1;
      ack[1] = 1'b1;
      tick();
      irq[1] = 1'b0;
      ack[1] = 1'b0;
      chk("setwins_irq", hirq[1], 1'b1);
      ack[1] = 1'b1;
      tick();
      ack[1] = 1'b0;
      chk("setwins_ack", hirq[1], 1'b0);
      chk("setwins_status", st(1), 32'h0);

      // Spurious done while idle.
      irq[2] = 1'b1;
      tick();
      irq[2] = 1'b0;
      chk("spur_status", st(2), 32'h10);
      chk("spur_irq", hirq[2], 1'b0);
      chk("spur_nostart", start, '0);
      irq[2] = 1'b1;
      ack[2] = 1'b1;
      tick();
      irq[2] = 1'b0;
      ack[2] = 1'b0;
      chk("spur_setwins", st(2), 32'h10);
      ack[2] = 1'b1;
      tick();
      ack[2] = 1'b0;
      chk("spur_cleared", st(2), 32'h0);

      // Spurious done during the launch cycle.
      write(6, 32'h66, 1'b1);
      tick();
      we[6] = 1'b0;
      tick();
      chk("launch_start", start[6], 1'b1);
      irq[6] = 1'b1;
      tick();
      irq[6] = 1'b0;
      chk("launch_spur", st(6), 32'h11);
      chk("launch_noirq", hirq[6], 1'b0);
      irq[6] = 1'b1;
      tick();
      irq[6] = 1'b0;
      chk("launch_done", st(6), 32'h12);
      ack[6] = 1'b1;
      tick();
      ack[6] = 1'b0;
      chk("launch_cleared", st(6), 32'h0);

      // Push and pop in the same cycle while full.
      start_job(7, 32'h71);
      write(7, 32'h72, 1'b1);
      tick();
      write(7, 32'h73, 1'b1);
      tick();
      write(7, 32'h74, 1'b1);
      irq[7] = 1'b1;
      tick();
      we[7]  = 1'b0;
      irq[7] = 1'b0;
      chk("pp_start", start[7], 1'b1);
      chk("pp_full", full[7], 1'b1);
      chk("pp_status", st(7), 32'h203);
      for (int k = 0; k < 2; k++) begin
         tick();
         irq[7] = 1'b1;
         tick();
         irq[7] = 1'b0;
         chk("pp_drain_start", start[7], 1'b1);
      end
      tick();
      irq[7] = 1'b1;
      tick();
      irq[7] = 1'b0;
      chk("pp_idle", st(7), 32'h2);
      ack[7] = 1'b1;
      tick();
      ack[7] = 1'b0;

      // No watchdog in the default build: BUSY persists.
      start_job(4, 32'h44);
      tick(150);
      chk("wd_busy", st(4), 32'h1);
      chk("wd_noirq", hirq[4], 1'b0);
      finish_job(4);

      // Reset mid-job with one queued command.
      start_job(5, 32'h51);
      write(5, 32'h52, 1'b1);
      tick();
      we[5] = 1'b0;
      chk("mid_status", st(5), 32'h101);
      rst = 1'b1;
      tick();
      chk("mid_rst_start", start, '0);
      chk("mid_rst_cmd", mcmd, '0);
      chk("mid_rst_irq", hirq, '0);
      chk("mid_rst_status", status, '0);
      chk("mid_rst_full", full, '0);
      rst = 1'b0;
      exp_q[5].delete();
      tick(2);
      irq[5] = 1'b1;
      tick();
      irq[5] = 1'b0;
      chk("mid_late_done", st(5), 32'h10);
      chk("mid_late_irq", hirq[5], 1'b0);
      chk("mid_late_nostart", start, '0);
      tick(4);
      ack[5] = 1'b1;
      tick();
      ack[5] = 1'b0;

      for (int h = 0; h < NH; h++) chk("sb_drained", 256'(exp_q[h].size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pito_mvu_launcher.md
PITO_MVU_LAUNCHER -- requirements
Module: pito_mvu_launcher

Interface
REQ-001 SHALL take parameter NUM_HARTS, default 8, number of harts and of MVU channels (1..16).
REQ-002 SHALL take parameter CMD_DEPTH, default 2, per-hart command FIFO depth (power of 2, 1..8).
REQ-003 SHALL take parameter MVU_TIMEOUT, default 65535, watchdog limit in cycles (used only with PITO_MVU_TIMEOUT_EN).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port csr_mvucommand_we  input  NUM_HARTS  per-hart write strobe of command CSR.
REQ-008 SHALL have port csr_mvucommand  input  32*NUM_HARTS  per-hart command value; hart h in bits [32h+31:32h].
REQ-009 SHALL have port mvu_irq_i  input  NUM_HARTS  per-MVU one-cycle done pulse.
REQ-010 SHALL have port irq_ack_i  input  NUM_HARTS  per-hart interrupt acknowledge.
REQ-011 SHALL have port mvu_start  output  NUM_HARTS  per-MVU one-cycle launch pulse.
REQ-012 SHALL have port mvu_command  output  32*NUM_HARTS  command of the job being launched/running.
REQ-013 SHALL have port hart_irq_o  output  NUM_HARTS  level interrupt to hart.
REQ-014 SHALL have port csr_mvustatus  output  32*NUM_HARTS  per-hart status word.
REQ-015 SHALL have port cmd_full_o  output  NUM_HARTS  per-hart FIFO full.

Function
REQ-016 SHALL keep NUM_HARTS fully independent channels; no cross-hart arbitration.
REQ-017 SHALL push csr_mvucommand into hart FIFO on csr_mvucommand_we when not full; write when full dropped, overflow sticky set.
REQ-018 SHALL allow push and pop in same cycle, including when full (pop frees slot, push accepted).
REQ-019 SHALL implement per-hart FSM IDLE -> LAUNCH -> BUSY -> IDLE.
REQ-020 IDLE: FIFO non-empty -> pop head into mvu_command, go LAUNCH.
REQ-021 LAUNCH: mvu_start high exactly this cycle, go BUSY unconditionally.
REQ-022 BUSY: mvu_irq_i -> set irq pending; FIFO non-empty -> pop and go LAUNCH next cycle, else IDLE.
REQ-023 Latency: write in cycle t to empty FIFO with FSM IDLE -> mvu_start high in cycle t+2.
REQ-024 mvu_command SHALL hold its value from LAUNCH until the next pop.
REQ-025 mvu_irq_i in IDLE or LAUNCH SHALL be ignored for FSM and set spurious sticky.
REQ-026 hart_irq_o SHALL equal irq pending; set cycle after done; cleared by irq_ack_i; set wins over ack in same cycle.
REQ-027 irq_ack_i SHALL also clear overflow, timeout and spurious sticky bits (set wins on coincidence).
REQ-028 Status: bit0 busy (LAUNCH/BUSY), bit1 irq pending, bit2 overflow, bit3 timeout, bit4 spurious, bits[11:8] FIFO count, others 0.
REQ-029 cmd_full_o SHALL be high when FIFO count equals CMD_DEPTH.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 rst SHALL flush all FIFOs, force IDLE, clear all sticky/pending bits and counters.
REQ-032 During/after rst: mvu_start, mvu_command, hart_irq_o, csr_mvustatus, cmd_full_o all 0.
REQ-033 rst mid-job SHALL not abort the MVU; its later done pulse SHALL be counted as spurious.
REQ-034 Writes coinciding with rst SHALL be discarded.

Configuration
REQ-035 Macro PITO_MVU_TIMEOUT_EN defined: per-hart cycle counter runs in BUSY; reaching MVU_TIMEOUT forces IDLE (or LAUNCH if FIFO non-empty), sets timeout sticky and irq pending.
REQ-036 done pulse in same cycle as timeout SHALL be treated as done, timeout bit not set.
REQ-037 Macro undefined: no counter logic, BUSY exits only on mvu_irq_i, status bit3 reads 0.

Verification
REQ-038 Hart 0 write 0x0000_00A5 at cycle 10 -> mvu_start[0] at cycle 12, mvu_command[31:0]=0xA5, status bit0=1.
REQ-039 CMD_DEPTH=2, hart 3 busy, three writes -> third dropped, cmd_full_o[3]=1, status bit2=1, count=2; two irqs -> two more launches in order.
REQ-040 mvu_irq_i[1] in BUSY with irq_ack_i[1] same cycle -> hart_irq_o[1]=1 next cycle; ack following cycle -> 0.
REQ-041 mvu_irq_i[2] while IDLE -> no FSM change, status bit4=1, hart_irq_o[2]=0.
REQ-042 PITO_MVU_TIMEOUT_EN, MVU_TIMEOUT=100, no irq -> IDLE after 100 BUSY cycles, status bit3=1, hart_irq_o=1; undefined -> stays BUSY.
REQ-043 rst asserted while hart 5 BUSY with 1 queued -> all outputs 0 next cycle, later done sets only bit4.
